// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program into instruction memory, releases the core,
// then stops it on a stable PC (halt) or when the run-cycle budget runs out.
module imem_boot_loader #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 256,
    parameter int STALL_CYCLES = 4,
    parameter int MAX_CYCLES   = 1024,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(MAX_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [XLEN-1:0] s_data,
    input  logic            s_last,
    output logic            imem_we,
    output logic [AW-1:0]   imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            core_reset,
    output logic            core_clk_en,
    input  logic [XLEN-1:0] core_pc,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic            timeout,
    output logic [AW:0]     words_loaded,
    output logic [CW-1:0]   cycle_count
);
    localparam int SW = $clog2(STALL_CYCLES);
    localparam logic [AW:0] LAST_WORD = (AW + 1)'(DEPTH - 1);
    localparam logic [SW-1:0] HALT_CNT = SW'(STALL_CYCLES - 1);
    localparam logic [CW-1:0] BUDGET = CW'(MAX_CYCLES);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERROR} state_t;

    state_t          state;
    logic [SW-1:0]   stable;
    logic [XLEN-1:0] prev_pc;
    logic            have_prev;
    logic [SW-1:0]   stable_next;
    logic [CW-1:0]   cycle_next;

    assign s_ready     = state == LOAD;
    assign imem_we     = s_ready && s_valid;
    assign imem_addr   = words_loaded[AW-1:0];
    assign imem_wdata  = s_data;
    assign stable_next = (have_prev && core_pc == prev_pc) ? stable + 1'b1 : '0;
    assign cycle_next  = (cycle_count == BUDGET) ? cycle_count : cycle_count + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            core_reset   <= 1'b1;
            core_clk_en  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            words_loaded <= '0;
            cycle_count  <= '0;
            stable       <= '0;
            prev_pc      <= '0;
            have_prev    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state        <= LOAD;
                        core_reset   <= 1'b1;
                        core_clk_en  <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        overflow     <= 1'b0;
                        timeout      <= 1'b0;
                        words_loaded <= '0;
                        cycle_count  <= '0;
                        stable       <= '0;
                        have_prev    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (imem_we) begin
                        words_loaded <= words_loaded + 1'b1;
                        if (s_last) begin
                            state       <= RUN;
                            core_reset  <= 1'b0;
                            core_clk_en <= 1'b1;
                        end else if (words_loaded == LAST_WORD) begin
                            // memory is full but the stream claims more words
                            state      <= ERROR;
                            overflow   <= 1'b1;
                            busy       <= 1'b0;
                            core_reset <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    cycle_count <= cycle_next;
                    prev_pc     <= core_pc;
                    have_prev   <= 1'b1;
                    stable      <= stable_next;
                    // halt is checked first so it wins over an expiring budget
                    if (stable_next == HALT_CNT) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        core_clk_en <= 1'b0;
                    end else if (cycle_next == BUDGET) begin
                        state       <= ERROR;
                        timeout     <= 1'b1;
                        busy        <= 1'b0;
                        core_clk_en <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized bench with a write scoreboard and a window-based halt/timeout model.
module tb_imem_boot_loader;
    localparam int DEPTH = 4;
    localparam int STALL = 4;
    localparam int MAXC  = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(MAXC + 1);

    logic          clk = 0, reset = 0, start = 0, s_valid = 0, s_last = 0;
    logic [31:0]   s_data = 0, core_pc = 0;
    logic          s_ready, imem_we, core_reset, core_clk_en, busy, done, overflow, timeout;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   words_loaded;
    logic [CW-1:0] cycle_count;

    imem_boot_loader #(.XLEN(32), .DEPTH(DEPTH), .STALL_CYCLES(STALL), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset), .core_clk_en(core_clk_en),
        .core_pc(core_pc), .busy(busy), .done(done), .overflow(overflow), .timeout(timeout),
        .words_loaded(words_loaded), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [AW-1:0] addr; logic [31:0] data;} wr_t;
    wr_t         exp_q[$];
    wr_t         mon_w;
    int          n_checks = 0, n_fail = 0;
    bit          saw_en = 0;
    logic [31:0] prog[DEPTH];
    logic [31:0] seq[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (core_clk_en) saw_en = 1;
        if (imem_we) begin
            if (exp_q.size() == 0) check("unexpected_write", 32'(imem_addr), 32'hffff_ffff);
            else begin
                mon_w = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(mon_w.addr));
                check("wr_data", imem_wdata, mon_w.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    // gap_mode: 0 back-to-back, 1 random gaps with stray start pulses, 2 valid pattern 1,0,0,1
    task automatic load(input int n, input bit last, input int gap_mode);
        for (int i = 0; i < n; i++) begin
            int g;
            g = gap_mode == 2 ? (i == 1 ? 2 : 0) : gap_mode == 1 ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                s_valid = 0;
                start = gap_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
            start   = 0;
            s_valid = 1;
            s_data  = prog[i];
            s_last  = last && i == n - 1;
            exp_q.push_back('{addr: AW'(i), data: prog[i]});
            tick();
        end
        s_valid = 0;
        s_last  = 0;
    endtask

    task automatic fill_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    endtask

    task automatic gen_seq(input int stay_pct);
        logic [31:0] pc;
        pc = $urandom & ~32'h3;
        for (int i = 0; i < 64; i++) begin
            seq[i] = pc;
            if (int'($urandom_range(0, 99)) >= stay_pct) pc += 4;
        end
    endtask

    // Halt = the last STALL sampled PCs are identical; otherwise the budget ends the run.
    task automatic model(output bit exp_done, output int exp_cc);
        exp_done = 0;
        exp_cc   = MAXC;
        for (int i = 0; i < MAXC; i++) begin
            bit same;
            same = i >= STALL - 1;
            for (int k = 1; k < STALL && same; k++) if (seq[i-k] != seq[i]) same = 0;
            if (same) begin
                exp_done = 1;
                exp_cc   = i + 1;
                return;
            end
        end
    endtask

    task automatic run_and_check();
        int cycles, exp_cc;
        bit exp_done;
        cycles = 0;
        while (core_clk_en && cycles < 64) begin
            core_pc = seq[cycles];
            cycles++;
            tick();
        end
        model(exp_done, exp_cc);
        check("run_cycles", 32'(cycles), 32'(exp_cc));
        check("done", 32'(done), 32'(exp_done));
        check("timeout", 32'(timeout), 32'(!exp_done));
        check("cycle_count", 32'(cycle_count), 32'(exp_cc));
        check("frozen_clk_en", 32'(core_clk_en), 0);
        check("frozen_core_reset", 32'(core_reset), 0);
        check("busy_after_run", 32'(busy), 0);
        check("overflow_after_run", 32'(overflow), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_core_reset"}, 32'(core_reset), 1);
        check({tag, "_core_clk_en"}, 32'(core_clk_en), 0);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_imem_we"}, 32'(imem_we), 0);
        check({tag, "_status"}, 32'({busy, done, overflow, timeout}), 0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 0);
    endtask

    initial begin
        tick();
        check_reset_state("reset");
        reset = 1;
        tick();

        // three-instruction program, halts on PC 8
        pulse_start();
        check("busy_in_load", 32'(busy), 1);
        prog[0] = 32'h005303b3;
        prog[1] = 32'h00628633;
        prog[2] = 32'h0000006f;
        load(3, 1, 0);
        check("words_loaded_3", 32'(words_loaded), 3);
        check("run_clk_en", 32'(core_clk_en), 1);
        check("run_core_reset", 32'(core_reset), 0);
        check("run_s_ready", 32'(s_ready), 0);
        seq[0] = 0;
        seq[1] = 4;
        for (int i = 2; i < 64; i++) seq[i] = 8;
        run_and_check();

        // restart from DONE clears everything; gapped load then timeout
        pulse_start();
        check("restart_status", 32'({done, overflow, timeout}), 0);
        check("restart_words", 32'(words_loaded), 0);
        check("restart_cycles", 32'(cycle_count), 0);
        check("restart_s_ready", 32'(s_ready), 1);
        fill_prog();
        load(2, 1, 2);
        check("words_loaded_gapped", 32'(words_loaded), 2);
        gen_seq(0);
        run_and_check();

        // overflow: DEPTH words without s_last
        pulse_start();
        saw_en = 0;
        fill_prog();
        load(DEPTH, 0, 0);
        check("overflow", 32'(overflow), 1);
        check("overflow_words", 32'(words_loaded), DEPTH);
        check("overflow_busy", 32'(busy), 0);
        check("overflow_s_ready", 32'(s_ready), 0);
        s_valid = 1;
        tick();
        tick();
        s_valid = 0;
        check("overflow_never_released", 32'(saw_en), 0);

        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            pulse_start();
            fill_prog();
            load(n, 1, 1);
            check("rand_words_loaded", 32'(words_loaded), 32'(n));
            gen_seq($urandom_range(30, 90));
            run_and_check();
        end

        // reset in the middle of a run
        pulse_start();
        fill_prog();
        load(2, 1, 0);
        for (int i = 0; i < 5; i++) begin
            core_pc = 32'(i * 4);
            tick();
        end
        check("mid_run_cycles", 32'(cycle_count), 5);
        reset = 0;
        #1;
        check_reset_state("async_reset");
        tick();
        reset = 1;
        tick();
        pulse_start();
        fill_prog();
        load(3, 1, 0);
        check("reload_words", 32'(words_loaded), 3);
        gen_seq(70);
        run_and_check();

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
